// File: rtl/shift_cmd_sequencer_if.sv
// Command, shifter-drive and result signals of shift_cmd_sequencer.
// res_count exists only when SHIFT_SEQ_STATS_EN is defined.
interface shift_cmd_sequencer_if #(
  parameter int unsigned DEPTH = 4
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [7:0]               cmd_data;
  logic [2:0]               cmd_amount;
  logic                     cmd_dir;
  logic [7:0]               sh_d_in;
  logic [2:0]               sh_shift_amount;
  logic                     sh_shift_direction;
  logic [7:0]               sh_out;
  logic                     res_valid;
  logic                     res_ready;
  logic [7:0]               res_data;
  logic [$clog2(DEPTH):0]   cmd_level;
  logic                     busy;
`ifdef SHIFT_SEQ_STATS_EN
  logic [15:0]              res_count;
`endif

  // Environment side: command source, shifter and result sink.
  modport master (
    output cmd_valid, cmd_data, cmd_amount, cmd_dir, sh_out, res_ready,
    input  cmd_ready, sh_d_in, sh_shift_amount, sh_shift_direction,
    input  res_valid, res_data, cmd_level, busy
`ifdef SHIFT_SEQ_STATS_EN
    , input res_count
`endif
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_amount, cmd_dir, sh_out, res_ready,
    output cmd_ready, sh_d_in, sh_shift_amount, sh_shift_direction,
    output res_valid, res_data, cmd_level, busy
`ifdef SHIFT_SEQ_STATS_EN
    , output res_count
`endif
  );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Queues shift commands, drives a combinational shifter from registers and returns
// its captured result on a valid/ready port. Optional feature macro: SHIFT_SEQ_STATS_EN.
module shift_cmd_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  shift_cmd_sequencer_if.slave   bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StSample, StHold} state_e;

  state_e          state_q, state_d;
  logic [11:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [7:0]      sh_d_q, sh_d_d;
  logic [2:0]      sh_amt_q, sh_amt_d;
  logic            sh_dir_q, sh_dir_d;
  logic            res_valid_q, res_valid_d;
  logic [7:0]      res_data_q, res_data_d;

  logic full, empty, push, pop, capture, clr_res;
  logic [11:0] head;

  assign full  = (level_q == LvlW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = bus.cmd_valid && !full;
  assign head  = mem_q[rd_ptr_q];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!empty) state_d = StSample;
      StSample: state_d = StHold;
      StHold:   if (bus.res_ready) state_d = empty ? StIdle : StSample;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    clr_res = 1'b0;
    unique case (state_q)
      StIdle:   pop = !empty;
      StSample: capture = 1'b1;
      StHold: begin
        if (bus.res_ready) begin
          clr_res = 1'b1;
          pop     = !empty;
        end
      end
      default: ;
    endcase
  end

  // FIFO bookkeeping; storage needs no reset since level gates every read.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d  = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.cmd_dir, bus.cmd_amount, bus.cmd_data};
    end
  end

  always_comb begin
    sh_d_d      = pop ? head[7:0]  : sh_d_q;
    sh_amt_d    = pop ? head[10:8] : sh_amt_q;
    sh_dir_d    = pop ? head[11]   : sh_dir_q;
    res_data_d  = capture ? bus.sh_out : res_data_q;
    res_valid_d = res_valid_q;
    if (capture) begin
      res_valid_d = 1'b1;
    end else if (clr_res) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      sh_d_q      <= '0;
      sh_amt_q    <= '0;
      sh_dir_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      sh_d_q      <= sh_d_d;
      sh_amt_q    <= sh_amt_d;
      sh_dir_q    <= sh_dir_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

`ifdef SHIFT_SEQ_STATS_EN
  logic [15:0] res_count_q, res_count_d;

  assign res_count_d = (res_valid_q && bus.res_ready) ? res_count_q + 16'd1 : res_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_count_q <= '0;
    end else begin
      res_count_q <= res_count_d;
    end
  end

  assign bus.res_count = res_count_q;
`endif

  assign bus.cmd_ready          = !full;
  assign bus.sh_d_in            = sh_d_q;
  assign bus.sh_shift_amount    = sh_amt_q;
  assign bus.sh_shift_direction = sh_dir_q;
  assign bus.res_valid          = res_valid_q;
  assign bus.res_data           = res_data_q;
  assign bus.cmd_level          = level_q;
  assign bus.busy               = (state_q != StIdle) || !empty;
endmodule
